// File: rtl/sm83_alu_seq_pkg.sv
// Shared types and constants for the SM83 ALU sequencing controller.
// Covers the FSM states, the BCD correction constants and the shift kinds selected by op543.
package sm83_alu_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DAA   = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

  localparam logic [4:0] BCD_MAX  = 5'd9;
  localparam logic [4:0] DAA_CORR = 5'd6;

  typedef enum logic [2:0] {
    SK_RLC = 3'd0,
    SK_RRC = 3'd1,
    SK_RL  = 3'd2,
    SK_RR  = 3'd3,
    SK_SLA = 3'd4,
    SK_SRA = 3'd5,
    SK_SLL = 3'd6,
    SK_SRL = 3'd7
  } shift_kind_e;

  // Bit shifted into the ALU for one step of the given shift kind.
  function automatic logic shift_in_sel(shift_kind_e kind, logic dbh, logic dbl, logic carry);
    logic res;
    case (kind)
      SK_RLC, SK_SRA: res = dbh;
      SK_RRC:         res = dbl;
      SK_RL, SK_RR:   res = carry;
      SK_SLL:         res = 1'b1;
      default:        res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/sm83_alu_seq_control_daa_digit.sv
// One-nibble decimal adjust: adds or subtracts the 6 correction for a single BCD digit.
// The ripple out is the nibble carry into the next digit; corr reports the correction decision.
module sm83_daa_digit
  import sm83_alu_seq_pkg::*;
(
  input  logic       i_sub,
  input  logic [3:0] i_digit,
  input  logic       i_ripple,
  input  logic       i_dc,
  output logic [3:0] o_digit,
  output logic       o_ripple,
  output logic       o_corr
);

  logic [4:0] w_t;
  logic [4:0] w_sum;
  logic       w_corr;

  always_comb begin
    w_t    = {1'b0, i_digit} + {4'b0000, i_ripple};
    w_corr = i_dc | (w_t > BCD_MAX);
    w_sum  = 5'd0;
    if (i_sub) begin
      w_sum    = {1'b0, i_digit} - (i_dc ? DAA_CORR : 5'd0);
      o_ripple = 1'b0;
      o_corr   = i_dc;
    end else begin
      w_sum    = w_t + (w_corr ? DAA_CORR : 5'd0);
      o_ripple = w_sum[4];
      o_corr   = w_corr;
    end
    o_digit = w_sum[3:0];
  end

endmodule

// File: rtl/sm83_alu_seq_control.sv
// Sequencing controller for the SM83 ALU: multi-step shift strobes, digit-serial DAA
// and the buffered branch condition, all in one clock domain.
module sm83_alu_seq_control
  import sm83_alu_seq_pkg::*;
#(
  parameter  int DIGITS    = 2,
  parameter  int SHIFT_MAX = 8,
  localparam int CW        = $clog2(SHIFT_MAX + 1),
  localparam int W         = 4 * DIGITS,
  localparam int IW        = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [2:0]    op543,
  input  logic          pri_carry,
  input  logic          shift_start,
  input  logic [CW-1:0] shift_count,
  input  logic          shift_dbh,
  input  logic          shift_dbl,
  output logic          shift_l,
  output logic          shift_r,
  output logic          shift_into_alu,
  output logic          shift_carry,
  input  logic          daa_start,
  input  logic          daa_sub,
  input  logic [W-1:0]  daa_value,
  input  logic [DIGITS-1:0] daa_dc,
  output logic [W-1:0]  daa_result,
  output logic          daa_carry_out,
  input  logic          cond_we,
  input  logic          zero,
  input  logic          carry,
  output logic          cond_result,
  output logic          busy,
  output logic          done
);

  seq_state_e        r_state;
  shift_kind_e       r_kind;
  logic [CW-1:0]     r_count;
  logic              r_carry;
  logic [W-1:0]      r_value;
  logic [DIGITS-1:0] r_dc;
  logic              r_sub;
  logic [IW-1:0]     r_idx;
  logic              r_ripple;
  logic [W-1:0]      r_acc;
  logic [W-1:0]      r_result;
  logic              r_daa_c;
  logic              r_cond;

  logic [3:0]        w_digit;
  logic [3:0]        w_dig_out;
  logic              w_rip_out;
  logic              w_corr_out;
  logic [W-1:0]      w_acc_merged;
  logic              w_last_digit;
  logic              w_shift_out;
  logic [CW-1:0]     w_count_clamped;

  assign w_digit         = r_value[r_idx*4 +: 4];
  assign w_last_digit    = (r_idx == IW'(DIGITS - 1));
  assign w_shift_out     = r_kind[0] ? shift_dbl : shift_dbh;
  assign w_count_clamped = (shift_count > CW'(SHIFT_MAX)) ? CW'(SHIFT_MAX) : shift_count;

  sm83_daa_digit u_digit (
    .i_sub    (r_sub),
    .i_digit  (w_digit),
    .i_ripple (r_ripple),
    .i_dc     (r_dc[r_idx]),
    .o_digit  (w_dig_out),
    .o_ripple (w_rip_out),
    .o_corr   (w_corr_out)
  );

  // Partial result with the digit being corrected this cycle folded in.
  always_comb begin
    w_acc_merged = r_acc;
    w_acc_merged[r_idx*4 +: 4] = w_dig_out;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_kind   <= SK_RLC;
      r_count  <= '0;
      r_carry  <= 1'b0;
      r_value  <= '0;
      r_dc     <= '0;
      r_sub    <= 1'b0;
      r_idx    <= '0;
      r_ripple <= 1'b0;
      r_acc    <= '0;
      r_result <= '0;
      r_daa_c  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (daa_start) begin
            r_value  <= daa_value;
            r_dc     <= daa_dc;
            r_sub    <= daa_sub;
            r_idx    <= '0;
            r_ripple <= 1'b0;
            r_acc    <= '0;
            r_state  <= ST_DAA;
          end else if (shift_start) begin
            r_kind  <= shift_kind_e'(op543);
            r_carry <= pri_carry;
            r_count <= w_count_clamped;
            r_state <= (shift_count == '0) ? ST_DONE : ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_carry <= w_shift_out;
          r_count <= r_count - CW'(1);
          if (r_count == CW'(1)) r_state <= ST_DONE;
        end
        ST_DAA: begin
          r_acc    <= w_acc_merged;
          r_ripple <= w_rip_out;
          r_idx    <= r_idx + IW'(1);
          if (w_last_digit) begin
            r_result <= w_acc_merged;
            r_daa_c  <= w_corr_out;
            r_state  <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cond <= 1'b0;
    end else if (cond_we) begin
      case (op543[1:0])
        2'd0:    r_cond <= ~zero;
        2'd1:    r_cond <= zero;
        2'd2:    r_cond <= ~carry;
        default: r_cond <= carry;
      endcase
    end
  end

  assign shift_l        = (r_state == ST_SHIFT) & ~r_kind[0];
  assign shift_r        = (r_state == ST_SHIFT) & r_kind[0];
  assign shift_into_alu = (r_state == ST_SHIFT) & shift_in_sel(r_kind, shift_dbh, shift_dbl, r_carry);
  assign shift_carry    = r_carry;
  assign daa_result     = r_result;
  assign daa_carry_out  = r_daa_c;
  assign cond_result    = r_cond;
  assign busy           = (r_state == ST_SHIFT) | (r_state == ST_DAA);
  assign done           = (r_state == ST_DONE);

endmodule
